// File: rtl/plot_sink_pkg.sv
// Shared types and constants for the pixel-plot sink: screen geometry,
// FIFO entry layout and drain FSM states.
package plot_sink_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int FB_AW    = 15;

  typedef struct packed {
    logic [FB_AW-1:0] addr;
    logic [2:0]       colour;
  } pixel_entry_t;

  typedef enum logic {S_IDLE, S_WRITE} drain_state_t;

  // y*160+x built from shifts so it maps to adders, not a multiplier
  function automatic logic [FB_AW-1:0] plot_addr(input logic [7:0] x, input logic [6:0] y);
    logic [FB_AW-1:0] yw;
    yw = {8'd0, y};
    return (yw << 7) + (yw << 5) + {7'd0, x};
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty derived from an occupancy count.
module sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_push, do_pop;

  always_comb begin
    // a push while full is refused even if a pop frees a slot this cycle
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
endmodule

// File: rtl/plot_sink.sv
// Receives plot strobes, clips off-screen pixels, buffers the rest and
// drains them to a framebuffer write port that may stall via fb_ready.
module plot_sink
  import plot_sink_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int X_MAX      = 160,
  parameter int Y_MAX      = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic [2:0]  vga_colour,
  input  logic        vga_plot,
  output logic        full,
  output logic        empty,
  output logic        overflow,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_data,
  output logic        fb_we,
  input  logic        fb_ready,
  output logic [15:0] pixel_count,
  output logic [15:0] clip_count
);
  drain_state_t state_q, state_d;
  pixel_entry_t push_entry, head;
  logic         clipped, push, pop;
  logic         overflow_q, overflow_d, fb_we_q, fb_we_d;
  logic [14:0]  fb_addr_q, fb_addr_d;
  logic [2:0]   fb_data_q, fb_data_d;
  logic [15:0]  pixel_count_q, pixel_count_d, clip_count_q, clip_count_d;

  sync_fifo #(.WIDTH($bits(pixel_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // clip before the full check so off-screen pixels never raise overflow
  always_comb begin
    clipped           = vga_plot && (int'(vga_x) >= X_MAX || int'(vga_y) >= Y_MAX);
    push              = vga_plot && !clipped && !full;
    push_entry.addr   = plot_addr(vga_x, vga_y);
    push_entry.colour = vga_colour;
    overflow_d        = overflow_q || (vga_plot && !clipped && full);
    clip_count_d      = clip_count_q;
    if (clipped && clip_count_q != 16'hFFFF) clip_count_d = clip_count_q + 16'd1;
  end

  always_comb begin
    state_d       = state_q;
    fb_we_d       = fb_we_q;
    fb_addr_d     = fb_addr_q;
    fb_data_d     = fb_data_q;
    pixel_count_d = pixel_count_q;
    pop           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          fb_addr_d = head.addr;
          fb_data_d = head.colour;
          pop       = 1'b1;
          fb_we_d   = 1'b1;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (fb_ready) begin
          if (pixel_count_q != 16'hFFFF) pixel_count_d = pixel_count_q + 16'd1;
          if (!empty) begin
            fb_addr_d = head.addr;
            fb_data_d = head.colour;
            pop       = 1'b1;
          end else begin
            fb_we_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_data_q     <= '0;
      overflow_q    <= 1'b0;
      pixel_count_q <= '0;
      clip_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      fb_we_q       <= fb_we_d;
      fb_addr_q     <= fb_addr_d;
      fb_data_q     <= fb_data_d;
      overflow_q    <= overflow_d;
      pixel_count_q <= pixel_count_d;
      clip_count_q  <= clip_count_d;
    end
  end

  assign overflow    = overflow_q;
  assign fb_we       = fb_we_q;
  assign fb_addr     = fb_addr_q;
  assign fb_data     = fb_data_q;
  assign pixel_count = pixel_count_q;
  assign clip_count  = clip_count_q;
endmodule

// File: tb/tb_plot_sink.sv
// Scoreboard bench for plot_sink: expected writes are queued as pixels are
// plotted and consumed by a monitor when the framebuffer accepts a write.
module tb_plot_sink;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        full, empty, overflow, fb_we, fb_ready;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic [15:0] pixel_count, clip_count;

  int pass_cnt = 0;
  int check_cnt = 0;
  logic [17:0] exp_q[$];
  int written[19200];
  logic stall_prev = 1'b0;
  logic [14:0] prev_addr;
  logic [2:0]  prev_data;

  plot_sink dut (
    .clk(clk), .reset(reset), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .full(full), .empty(empty), .overflow(overflow),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready),
    .pixel_count(pixel_count), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  // inputs change at posedge+1, so at negedge fb_we&&fb_ready means the write lands next edge
  always @(negedge clk) begin
    if (!reset && fb_we) begin
      if (stall_prev) begin
        check_cnt++;
        if (fb_addr !== prev_addr || fb_data !== prev_data)
          $display("FAIL stall_hold: addr=%0d data=%0d, held must be addr=%0d data=%0d",
                   fb_addr, fb_data, prev_addr, prev_data);
        else pass_cnt++;
      end
      if (fb_ready) begin
        logic [17:0] e;
        check_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_write: addr=%0d data=%0d, no write expected", fb_addr, fb_data);
        end else begin
          e = exp_q.pop_front();
          if ({fb_addr, fb_data} !== e)
            $display("FAIL write_order: addr=%0d data=%0d, expected addr=%0d data=%0d",
                     fb_addr, fb_data, e[17:3], e[2:0]);
          else pass_cnt++;
        end
        if (fb_addr < 15'd19200) written[fb_addr]++;
      end
    end
    stall_prev = !reset && fb_we && !fb_ready;
    prev_addr  = fb_addr;
    prev_data  = fb_data;
  end

  task automatic plot(input int x, input int y, input logic [2:0] c, input bit store);
    vga_x = 8'(x); vga_y = 7'(y); vga_colour = c; vga_plot = 1'b1;
    if (store) exp_q.push_back({15'(y * 160 + x), c});
    @(posedge clk); #1;
    vga_plot = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_drain(input int bound, input bit toggle, input string name);
    bit done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fb_we === 1'b0 && empty === 1'b1) done = 1;
      @(posedge clk); #1;
      if (toggle) fb_ready = ~fb_ready;
    end
    check_cnt++;
    if (!done) $display("FAIL %s_drain: timeout, %0d writes still pending", name, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    check_cnt++;
    if ({full, empty, overflow, fb_we, fb_addr, fb_data, pixel_count, clip_count} !==
        {1'b0, 1'b1, 1'b0, 1'b0, 15'd0, 3'd0, 16'd0, 16'd0})
      $display("FAIL reset_state: full=%b empty=%b ovf=%b we=%b addr=%0d data=%0d pc=%0d cc=%0d, expected 0 1 0 0 0 0 0 0",
               full, empty, overflow, fb_we, fb_addr, fb_data, pixel_count, clip_count);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    fb_ready = 1'b1;
    plot(80, 60, 3'b010, 1);
    @(negedge clk);
    check_cnt++;
    if (fb_we !== 1'b0) $display("FAIL single_early: fb_we=%b, expected 0", fb_we);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if ({fb_we, fb_addr, fb_data} !== {1'b1, 15'd9680, 3'd2})
      $display("FAIL single_write: we=%b addr=%0d data=%0d, expected 1 9680 2", fb_we, fb_addr, fb_data);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if ({fb_we, pixel_count, empty} !== {1'b0, 16'd1, 1'b1})
      $display("FAIL single_after: we=%b pc=%0d empty=%b, expected 0 1 1", fb_we, pixel_count, empty);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_clip();
    do_reset();
    fb_ready = 1'b1;
    plot(160, 0, 3'd5, 0);
    plot(0, 120, 3'd5, 0);
    plot(255, 127, 3'd5, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cnt++;
    if ({clip_count, empty, fb_we} !== {16'd3, 1'b1, 1'b0})
      $display("FAIL clip_count: cc=%0d empty=%b we=%b, expected 3 1 0", clip_count, empty, fb_we);
    else pass_cnt++;
    @(posedge clk); #1;
    plot(0, 0, 3'd6, 1);
    plot(159, 119, 3'd7, 1);
    wait_drain(20, 0, "clip");
    @(negedge clk);
    check_cnt++;
    if ({pixel_count, clip_count} !== {16'd2, 16'd3})
      $display("FAIL clip_edges: pc=%0d cc=%0d, expected 2 3", pixel_count, clip_count);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    do_reset();
    fb_ready = 1'b0;
    for (int x = 0; x < 18; x++) plot(x, 0, 3'(x), x < 17);
    @(negedge clk);
    check_cnt++;
    if ({full, overflow, fb_we, fb_addr} !== {1'b1, 1'b1, 1'b1, 15'd0})
      $display("FAIL ovf_stalled: full=%b ovf=%b we=%b addr=%0d, expected 1 1 1 0", full, overflow, fb_we, fb_addr);
    else pass_cnt++;
    @(posedge clk); #1;
    fb_ready = 1'b1;
    wait_drain(40, 0, "ovf");
    @(negedge clk);
    check_cnt++;
    if ({pixel_count, overflow} !== {16'd17, 1'b1})
      $display("FAIL ovf_after: pc=%0d ovf=%b, expected 17 1", pixel_count, overflow);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    do_reset();
    fb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      plot(10 + i, 3 * i, 3'(i + 1), 1);
      fb_ready = ~fb_ready;
    end
    wait_drain(40, 1, "stall");
    fb_ready = 1'b1;
    @(negedge clk);
    check_cnt++;
    if (pixel_count !== 16'd5) $display("FAIL stall_count: pc=%0d, expected 5", pixel_count);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    fb_ready = 1'b0;
    for (int i = 0; i < 10; i++) plot(i, 1, 3'd4, 0);
    plot(200, 0, 3'd4, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_cnt++;
    if ({fb_we, empty, full, overflow, pixel_count, clip_count} !==
        {1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0})
      $display("FAIL mid_reset: we=%b empty=%b full=%b ovf=%b pc=%0d cc=%0d, expected 0 1 0 0 0 0",
               fb_we, empty, full, overflow, pixel_count, clip_count);
    else pass_cnt++;
    @(posedge clk); #1;
    fb_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_cnt++;
    if (pixel_count !== 16'd0) $display("FAIL mid_stale: pc=%0d, expected 0", pixel_count);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_fullscreen();
    int bad = 0;
    do_reset();
    foreach (written[i]) written[i] = 0;
    fb_ready = 1'b1;
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) plot(x, y, 3'b001, 1);
    wait_drain(100, 0, "fill");
    for (int i = 0; i < 19200; i++) if (written[i] != 1) bad++;
    check_cnt++;
    if (bad != 0) $display("FAIL fill_coverage: %0d addresses not written exactly once, expected 0", bad);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if ({pixel_count, clip_count, overflow} !== {16'd19200, 16'd0, 1'b0})
      $display("FAIL fill_counts: pc=%0d cc=%0d ovf=%b, expected 19200 0 0", pixel_count, clip_count, overflow);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0; fb_ready = 1'b0;
    test_reset();
    test_single();
    test_clip();
    test_overflow();
    test_stall();
    test_reset_mid();
    test_fullscreen();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
